// File: rtl/light_monitor.sv
// Passive checker for a highway/country traffic-light controller: tracks the phase and flags illegal lights or timing.
// Latency: all outputs are registered one cycle after the sampled light/car. Backpressure: none, observe-only.
module light_monitor #(
    parameter int YELLOW_MIN = 3,
    parameter int YELLOW_MAX = 8,
    parameter int WAIT_MAX   = 64,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       car,
    input  logic [5:0] light,
    input  logic       clear,
    output logic [2:0] phase,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [7:0] err_count
);

    typedef enum logic [2:0] {
        IDLE = 3'd0, HG = 3'd1, HY = 3'd2, AR_C = 3'd3, CG = 3'd4, CY = 3'd5, AR_H = 3'd6
    } state_t;

    typedef enum logic [2:0] {P_HG, P_HY, P_CG, P_CY, P_AR, P_BAD} pat_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] Y_MIN   = CNT_W'(YELLOW_MIN);
    localparam logic [CNT_W-1:0] Y_MAX   = CNT_W'(YELLOW_MAX);
    localparam logic [CNT_W-1:0] W_MAX   = CNT_W'(WAIT_MAX);

    state_t           state, state_nxt;
    pat_t             pat, cur_pat;
    logic [CNT_W-1:0] dwell, dwell_nxt, wait_cnt, wait_nxt;
    logic             starved, starved_nxt;
    logic             ill_pat, ill_trans, stay, yellow, in_hg;
    logic             yel_short, yel_long, starve, evt;
    logic [2:0]       code;

    // light = {ctry g,y,r, hw g,y,r}
    always_comb begin
        case (light)
            6'b001100: pat = P_HG;
            6'b001010: pat = P_HY;
            6'b100001: pat = P_CG;
            6'b010001: pat = P_CY;
            6'b001001: pat = P_AR;
            default:   pat = P_BAD;
        endcase
    end

    always_comb begin
        case (state)
            HG:          cur_pat = P_HG;
            HY:          cur_pat = P_HY;
            CG:          cur_pat = P_CG;
            CY:          cur_pat = P_CY;
            AR_C, AR_H:  cur_pat = P_AR;
            default:     cur_pat = P_BAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            dwell    <= '0;
            wait_cnt <= '0;
            starved  <= 1'b0;
        end else begin
            state    <= state_nxt;
            dwell    <= dwell_nxt;
            wait_cnt <= wait_nxt;
            starved  <= starved_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ill_pat   = 1'b0;
        ill_trans = 1'b0;
        if (pat == P_BAD) begin
            ill_pat   = 1'b1;
            state_nxt = IDLE;
        end else if (state == IDLE) begin
            if (pat == P_HG)      state_nxt = HG;
            else if (pat == P_CG) state_nxt = CG;
        end else if (pat != cur_pat) begin
            ill_trans = 1'b1;
            case (state)
                HG:   if (pat == P_HY) begin state_nxt = HY; ill_trans = 1'b0; end
                HY:   if (pat == P_AR) begin state_nxt = AR_C; ill_trans = 1'b0; end
                      else if (pat == P_CG) begin state_nxt = CG; ill_trans = 1'b0; end
                AR_C: if (pat == P_CG) begin state_nxt = CG; ill_trans = 1'b0; end
                CG:   if (pat == P_CY) begin state_nxt = CY; ill_trans = 1'b0; end
                CY:   if (pat == P_AR) begin state_nxt = AR_H; ill_trans = 1'b0; end
                      else if (pat == P_HG) begin state_nxt = HG; ill_trans = 1'b0; end
                AR_H: if (pat == P_HG) begin state_nxt = HG; ill_trans = 1'b0; end
                default: ;
            endcase
            if (ill_trans) state_nxt = IDLE;
        end

        stay      = (state_nxt == state);
        yellow    = (state == HY) || (state == CY);
        in_hg     = (state == HG) && stay;
        dwell_nxt = stay ? ((dwell == CNT_MAX) ? dwell : dwell + 1'b1) : {{(CNT_W-1){1'b0}}, 1'b1};
        yel_short = yellow && !stay && (dwell < Y_MIN);
        // dwell == YELLOW_MAX now means the new value hits YELLOW_MAX+1; happens once per phase
        yel_long  = yellow && stay && (dwell == Y_MAX);
        wait_nxt  = (in_hg && car) ? ((wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + 1'b1) : '0;
        starve    = in_hg && car && (wait_nxt == W_MAX) && !starved;
        starved_nxt = in_hg ? (starved || starve) : 1'b0;

        evt  = 1'b1;
        if (ill_pat)        code = 3'd1;
        else if (ill_trans) code = 3'd2;
        else if (yel_short) code = 3'd3;
        else if (yel_long)  code = 3'd4;
        else if (starve)    code = 3'd6;
        else begin
            code = 3'd0;
            evt  = 1'b0;
        end
    end

    always_comb phase = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault      <= 1'b0;
            fault_code <= 3'd0;
            err_count  <= 8'd0;
        end else if (clear) begin
            fault      <= 1'b0;
            fault_code <= 3'd0;
            err_count  <= 8'd0;
        end else if (evt) begin
            fault <= 1'b1;
            if (!fault) fault_code <= code;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_light_monitor.sv
// Directed bench for light_monitor: legal cycle, each fault code, clear and async reset.
module tb_light_monitor;

    localparam logic [5:0] L_HG  = 6'b001100;
    localparam logic [5:0] L_HY  = 6'b001010;
    localparam logic [5:0] L_CG  = 6'b100001;
    localparam logic [5:0] L_CY  = 6'b010001;
    localparam logic [5:0] L_AR  = 6'b001001;
    localparam logic [5:0] L_BAD = 6'b100100;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       car = 1'b0;
    logic [5:0] light = L_AR;
    logic       clear = 1'b0;
    logic [2:0] phase;
    logic       fault;
    logic [2:0] fault_code;
    logic [7:0] err_count;

    int total = 0;
    int bad   = 0;

    light_monitor dut (
        .clk        (clk),
        .rst        (rst),
        .car        (car),
        .light      (light),
        .clear      (clear),
        .phase      (phase),
        .fault      (fault),
        .fault_code (fault_code),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic [5:0] l, input logic c, input int n);
        for (int i = 0; i < n; i++) begin
            light = l;
            car   = c;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] ph, input logic f,
                           input logic [2:0] fc, input logic [7:0] ec);
        chk({tag, ".phase"}, {5'd0, phase}, {5'd0, ph});
        chk({tag, ".fault"}, {7'd0, fault}, {7'd0, f});
        chk({tag, ".code"},  {5'd0, fault_code}, {5'd0, fc});
        chk({tag, ".errs"},  err_count, ec);
    endtask

    initial begin
        // reset state
        @(posedge clk);
        #1;
        chk_all("reset", 3'd0, 1'b0, 3'd0, 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // legal cycle with car pulses
        cyc(L_HG, 1'b0, 1);  chk("legal.hg_enter", {5'd0, phase}, 8'd1);
        cyc(L_HG, 1'b0, 3);
        cyc(L_HG, 1'b1, 3);
        cyc(L_HG, 1'b0, 3);  chk("legal.hg", {5'd0, phase}, 8'd1);
        cyc(L_HY, 1'b0, 1);  chk("legal.hy_enter", {5'd0, phase}, 8'd2);
        cyc(L_HY, 1'b0, 3);  chk("legal.hy", {5'd0, phase}, 8'd2);
        cyc(L_AR, 1'b0, 1);  chk("legal.arc", {5'd0, phase}, 8'd3);
        cyc(L_CG, 1'b1, 6);  chk("legal.cg", {5'd0, phase}, 8'd4);
        cyc(L_CY, 1'b0, 4);  chk("legal.cy", {5'd0, phase}, 8'd5);
        cyc(L_HG, 1'b0, 1);  chk_all("legal.end", 3'd1, 1'b0, 3'd0, 8'd0);

        // both green from HG, then resync
        cyc(L_BAD, 1'b0, 1); chk_all("badpat", 3'd0, 1'b1, 3'd1, 8'd1);
        cyc(L_HG, 1'b0, 1);  chk_all("badpat.resync", 3'd1, 1'b1, 3'd1, 8'd1);
        clear = 1'b1;
        cyc(L_HG, 1'b0, 1);
        clear = 1'b0;
        chk_all("clear1", 3'd1, 1'b0, 3'd0, 8'd0);

        // HG->CG illegal, then short yellow keeps first code
        cyc(L_CG, 1'b0, 1);  chk_all("trans", 3'd0, 1'b1, 3'd2, 8'd1);
        cyc(L_HG, 1'b0, 1);  chk("trans.resync", {5'd0, phase}, 8'd1);
        cyc(L_HY, 1'b0, 2);  chk("short.hy", err_count, 8'd1);
        cyc(L_AR, 1'b0, 1);  chk_all("short", 3'd3, 1'b1, 3'd2, 8'd2);
        clear = 1'b1;
        cyc(L_AR, 1'b0, 1);
        clear = 1'b0;
        chk_all("clear2", 3'd3, 1'b0, 3'd0, 8'd0);

        // yellow long: 9 samples of HY
        cyc(L_CG, 1'b0, 1);
        cyc(L_CY, 1'b0, 3);  chk("min_yellow_ok", err_count, 8'd0);
        cyc(L_HG, 1'b0, 1);  chk("cy_to_hg", {5'd0, phase}, 8'd1);
        cyc(L_HY, 1'b0, 8);  chk("long.at8", err_count, 8'd0);
        cyc(L_HY, 1'b0, 1);  chk_all("long.at9", 3'd2, 1'b1, 3'd4, 8'd1);
        cyc(L_HY, 1'b0, 1);  chk("long.once", err_count, 8'd1);
        cyc(L_AR, 1'b0, 1);  chk_all("long.exit", 3'd3, 1'b1, 3'd4, 8'd1);
        clear = 1'b1;
        cyc(L_AR, 1'b0, 1);
        clear = 1'b0;

        // starvation
        cyc(L_CG, 1'b0, 1);
        cyc(L_CY, 1'b0, 3);
        cyc(L_AR, 1'b0, 1);  chk("arh", {5'd0, phase}, 8'd6);
        cyc(L_HG, 1'b0, 1);  chk("arh_to_hg", {5'd0, phase}, 8'd1);
        cyc(L_HG, 1'b1, 63); chk("starve.at63", err_count, 8'd0);
        cyc(L_HG, 1'b1, 1);  chk_all("starve.at64", 3'd1, 1'b1, 3'd6, 8'd1);
        cyc(L_HG, 1'b1, 10);
        cyc(L_HG, 1'b0, 1);
        cyc(L_HG, 1'b1, 64); chk("starve.once", err_count, 8'd1);
        clear = 1'b1;
        cyc(L_HG, 1'b0, 1);
        clear = 1'b0;
        chk_all("clear3", 3'd1, 1'b0, 3'd0, 8'd0);

        // async reset mid-CY with a pending fault
        cyc(L_HY, 1'b0, 2);
        cyc(L_AR, 1'b0, 1);  chk("pre_rst.err", err_count, 8'd1);
        cyc(L_CG, 1'b0, 2);
        cyc(L_CY, 1'b0, 2);  chk("pre_rst.cy", {5'd0, phase}, 8'd5);
        rst = 1'b1;
        #1;
        chk_all("async_rst", 3'd0, 1'b0, 3'd0, 8'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(L_CY, 1'b0, 1);  chk_all("rst.idle_cy", 3'd0, 1'b0, 3'd0, 8'd0);
        cyc(L_CG, 1'b0, 1);  chk_all("rst.resync", 3'd4, 1'b0, 3'd0, 8'd0);

        // clear drops a same-cycle fault event
        clear = 1'b1;
        cyc(L_BAD, 1'b0, 1);
        clear = 1'b0;
        chk_all("clear_drop", 3'd0, 1'b0, 3'd0, 8'd0);
        cyc(L_CG, 1'b0, 1);  chk_all("clear_drop.resync", 3'd4, 1'b0, 3'd0, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/light_monitor.md
LIGHT_MONITOR -- requirements
Module: light_monitor

Interface
REQ-001 SHALL have parameter YELLOW_MIN, default 3, minimum legal yellow dwell in cycles.
REQ-002 SHALL have parameter YELLOW_MAX, default 8, maximum legal yellow dwell in cycles.
REQ-003 SHALL have parameter WAIT_MAX, default 64, maximum cycles car may be held high during highway green.
REQ-004 SHALL have parameter CNT_W, default 8, width of the dwell and wait counters.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 SHALL have port: clk  input  1  rising-edge clock.
REQ-007 SHALL have port: rst  input  1  asynchronous active-high reset.
REQ-008 SHALL have port: car  input  1  country-road car sensor, same signal the controller sees.
REQ-009 SHALL have port: light  input  6  {country g,y,r, highway g,y,r}; bit5 = country green, bit0 = highway red.
REQ-010 SHALL have port: clear  input  1  synchronous clear of fault, fault_code and err_count.
REQ-011 SHALL have port: phase  output  3  tracked phase: 0 IDLE, 1 HG, 2 HY, 3 AR_C, 4 CG, 5 CY, 6 AR_H.
REQ-012 SHALL have port: fault  output  1  sticky fault flag.
REQ-013 SHALL have port: fault_code  output  3  code of the first fault since reset or clear.
REQ-014 SHALL have port: err_count  output  8  saturating count of fault events.

Function
REQ-015 SHALL sample light and car every rising edge; all outputs registered, updated the cycle after the sampled cycle.
REQ-016 SHALL treat as legal patterns only: HG = hw G + ctry R; HY = hw Y + ctry R; CG = hw R + ctry G; CY = hw R + ctry Y; AR = both R.
REQ-017 SHALL raise code 1 (illegal pattern) on any other value, incl. per-road not one-hot and both roads non-red; state goes to IDLE.
REQ-018 SHALL allow only these transitions: HG->HY; HY->AR_C or CG; AR_C->CG; CG->CY; CY->AR_H or HG; AR_H->HG. An unchanged pattern holds state.
REQ-019 SHALL raise code 2 (illegal transition) on any other legal-pattern change out of a non-IDLE state; state goes to IDLE.
REQ-020 SHALL, in IDLE, enter HG or CG on the cycle after that pattern is sampled, with no transition check; other legal patterns keep IDLE.
REQ-021 SHALL count dwell from 1 on the first cycle of a state, +1 per stable cycle, saturating at 2^CNT_W-1.
REQ-022 SHALL raise code 3 (yellow short) when HY or CY is exited with dwell < YELLOW_MIN.
REQ-023 SHALL raise code 4 (yellow long) once per yellow phase, when dwell reaches YELLOW_MAX+1 while still yellow.
REQ-024 SHALL count consecutive cycles with car=1 in HG and raise code 6 (starvation) once per HG phase on reaching WAIT_MAX; the count resets when car=0 or on leaving HG.
REQ-025 SHALL resolve simultaneous faults in one cycle by priority 1 > 2 > 3 > 4 > 6; exactly one event is recorded per cycle.
REQ-026 SHALL, on a fault event, set fault=1, load fault_code only if fault was 0, and increment err_count, saturating at 255.
REQ-027 SHALL, on clear=1, zero fault, fault_code and err_count and drop any fault event that same cycle; phase tracking is unaffected.
REQ-028 SHALL leave codes 0, 5 and 7 unused; fault_code=0 means no fault.

Reset
REQ-029 SHALL, while rst=1, force phase=0 (IDLE), fault=0, fault_code=0, err_count=0, and dwell and wait counters to 0, asynchronously.
REQ-030 SHALL, on rst deassertion mid-sequence, restart from IDLE and resynchronise per REQ-020 without flagging a fault.

Verification
REQ-031 SHALL pass: legal cycle HG(10) HY(4) AR(1) CG(6) CY(4) HG, car pulsed -> phase 1,2,3,4,5,1; fault=0; err_count=0.
REQ-032 SHALL pass: light=6'b100100 (both green) for 1 cycle from HG -> fault=1, fault_code=1, err_count=1, phase=0, then HG resync.
REQ-033 SHALL pass: HG->CG directly -> fault_code=2; a subsequent HY of 2 cycles -> fault_code stays 2, err_count=2.
REQ-034 SHALL pass: HY held 9 cycles with YELLOW_MAX=8 -> code-4 event on the cycle after the 9th sample, exactly once; err_count +1.
REQ-035 SHALL pass: car=1 for 64 cycles in HG -> fault_code=6 once; clear=1 -> fault=0, err_count=0, phase still 1.
REQ-036 SHALL pass: rst asserted mid-CY -> all outputs 0 immediately; after release, CG sampled -> phase=4, no fault.
